// File: rtl/mm_cmd_scheduler.sv
// In-order command queue feeding a single-outstanding bus master with one response per command.
// Define MM_CMD_TIMEOUT_EN to abort a bus access after TIMEOUT cycles without bus_ack.
module mm_cmd_scheduler #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cmd_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] data_in,
    input  logic        cmd_valid,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_status,
    output logic        overflow,
    output logic        busy
);

    localparam int unsigned PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PtrW:0]   QFull  = (PtrW + 1)'(DEPTH);
    localparam logic [PtrW:0]   CntOne = (PtrW + 1)'(1);
    localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

    localparam logic [7:0] OpNop   = 8'h00;
    localparam logic [7:0] OpWrite = 8'h01;
    localparam logic [7:0] OpRead  = 8'h02;

    localparam logic [1:0] StatOk    = 2'b00;
    localparam logic [1:0] StatBadOp = 2'b01;

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e state_q, state_d;

    logic [7:0]  q_op   [DEPTH];
    logic [31:0] q_addr [DEPTH];
    logic [31:0] q_data [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic            overflow_q;

    logic        cur_we_q;
    logic [31:0] cur_addr_q, cur_wdata_q;
    logic [1:0]  res_status_q, res_status_d;
    logic [31:0] res_data_q, res_data_d;
    logic        rsp_valid_q;
    logic [31:0] rsp_data_q;
    logic [1:0]  rsp_status_q;

    logic        queue_empty, queue_full, idle;
    logic        bypass, pop, push, drop, load;
    logic [7:0]  head_op;
    logic [31:0] head_addr, head_data;

    logic unused_cmd_hi;
    assign unused_cmd_hi = ^cmd_in[31:8];

    assign queue_empty = (count_q == '0);
    assign queue_full  = (count_q == QFull);
    assign idle        = (state_q == StIdle);

    // An idle block with an empty queue takes the incoming command straight into execution.
    assign bypass = idle && queue_empty && cmd_valid;
    assign pop    = idle && !queue_empty;
    assign push   = cmd_valid && !bypass && (!queue_full || pop);
    assign drop   = cmd_valid && queue_full && !pop;
    assign load   = bypass || pop;

    assign head_op   = pop ? q_op[rd_ptr_q]   : cmd_in[7:0];
    assign head_addr = pop ? q_addr[rd_ptr_q] : addr_in;
    assign head_data = pop ? q_data[rd_ptr_q] : data_in;

    always_ff @(posedge clk) begin
        if (push) begin
            q_op[wr_ptr_q]   <= cmd_in[7:0];
            q_addr[wr_ptr_q] <= addr_in;
            q_data[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
            if (push && !pop) begin
                count_q <= count_q + CntOne;
            end else if (pop && !push) begin
                count_q <= count_q - CntOne;
            end
            if (drop) overflow_q <= 1'b1;
        end
    end

`ifdef MM_CMD_TIMEOUT_EN
    localparam logic [1:0]  StatTimeout = 2'b10;
    localparam logic [15:0] TmoLast     = 16'(TIMEOUT - 1);

    logic [15:0] tmo_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt_q <= '0;
        end else if (state_q == StIssue) begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end else begin
            tmo_cnt_q <= '0;
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        res_status_d = res_status_q;
        res_data_d   = res_data_q;
        case (state_q)
            StIdle: begin
                if (load) begin
                    res_data_d = '0;
                    if (head_op == OpRead || head_op == OpWrite) begin
                        state_d      = StIssue;
                        res_status_d = StatOk;
                    end else begin
                        state_d      = StResp;
                        res_status_d = (head_op == OpNop) ? StatOk : StatBadOp;
                    end
                end
            end
            StIssue: begin
                // An ack in the expiry cycle takes priority over the timeout.
                if (bus_ack) begin
                    state_d      = StResp;
                    res_status_d = StatOk;
                    if (!cur_we_q) res_data_d = bus_rdata;
                end
`ifdef MM_CMD_TIMEOUT_EN
                else if (tmo_cnt_q == TmoLast) begin
                    state_d      = StResp;
                    res_status_d = StatTimeout;
                    res_data_d   = '0;
                end
`endif
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            cur_we_q     <= 1'b0;
            cur_addr_q   <= '0;
            cur_wdata_q  <= '0;
            res_status_q <= StatOk;
            res_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            res_status_q <= res_status_d;
            res_data_q   <= res_data_d;
            if (load) begin
                cur_we_q    <= (head_op == OpWrite);
                cur_addr_q  <= head_addr;
                cur_wdata_q <= head_data;
            end
        end
    end

    // The response is registered out of RESP, so rsp_data/rsp_status only change with the strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_status_q <= StatOk;
        end else begin
            rsp_valid_q <= (state_q == StResp);
            if (state_q == StResp) begin
                rsp_data_q   <= res_data_q;
                rsp_status_q <= res_status_q;
            end
        end
    end

    assign bus_req    = (state_q == StIssue);
    assign bus_we     = cur_we_q;
    assign bus_addr   = cur_addr_q;
    assign bus_wdata  = cur_wdata_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_status = rsp_status_q;
    assign overflow   = overflow_q;
    assign busy       = !queue_empty || !idle;

endmodule

// File: tb/tb_mm_cmd_scheduler.sv
// Scoreboard bench for mm_cmd_scheduler: directed commands push expected responses,
// a negedge monitor pops and compares each rsp_valid strobe.
`timescale 1ns/1ps
module tb_mm_cmd_scheduler;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] cmd_in = '0, addr_in = '0, data_in = '0;
    logic        cmd_valid = 1'b0;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_status;
    logic        overflow, busy;

    always #5 clk = ~clk;

    mm_cmd_scheduler #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_in     (cmd_in),
        .addr_in    (addr_in),
        .data_in    (data_in),
        .cmd_valid  (cmd_valid),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_status (rsp_status),
        .overflow   (overflow),
        .busy       (busy)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  status;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   rsp_idx  = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    // Response monitor
    always @(negedge clk) begin
        if (reset && rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected: got status %0d data 0x%08h, expected no response",
                         rsp_status, rsp_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("rsp_data[%0d]", rsp_idx), rsp_data, e.data);
                check($sformatf("rsp_status[%0d]", rsp_idx), {30'd0, rsp_status},
                      {30'd0, e.status});
            end
            rsp_idx++;
        end
    end

    task automatic expect_rsp(input logic [31:0] d, input logic [1:0] s);
        exp_t e;
        e.data   = d;
        e.status = s;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [31:0] cmd, input logic [31:0] addr, input logic [31:0] data);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_in    = cmd;
        addr_in   = addr;
        data_in   = data;
    endtask

    task automatic idle_in();
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_in    = '0;
        addr_in   = '0;
        data_in   = '0;
    endtask

    // Bus responder for one access: acks after wait_cycles request cycles, rdata = addr ^ key.
    task automatic serve(input int wait_cycles, input logic [31:0] key, input int max_cycles,
                         output int req_cycles, output int first_at, output logic first_we,
                         output logic [31:0] first_addr, output logic [31:0] first_wdata);
        req_cycles  = 0;
        first_at    = -1;
        first_we    = 1'b0;
        first_addr  = '0;
        first_wdata = '0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (bus_req) begin
                if (req_cycles == 0) begin
                    first_at    = i;
                    first_we    = bus_we;
                    first_addr  = bus_addr;
                    first_wdata = bus_wdata;
                end
                req_cycles++;
                bus_ack   = (req_cycles > wait_cycles);
                bus_rdata = bus_addr ^ key;
            end else begin
                bus_ack = 1'b0;
                if (req_cycles > 0) break;
            end
        end
        bus_ack = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: got %0d responses outstanding, expected 0", name,
                     exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          rc, at;
        logic        we;
        logic [31:0] a, wd;
        logic [31:0] ovf_rd [5];

        ovf_rd = '{32'h5A5A0100, 32'h0, 32'h5A5A0108, 32'h0, 32'h5A5A0110};

        repeat (2) @(negedge clk);
        check("rst_bus_req", bus_req, 0);
        check("rst_bus_we", bus_we, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_wdata", bus_wdata, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_status", {30'd0, rsp_status}, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;

        // WRITE with zero-wait ack
        expect_rsp(32'h0, 2'b00);
        send(32'h01, 32'h10, 32'hDEADBEEF);
        idle_in();
        serve(0, 32'h0, 10, rc, at, we, a, wd);
        check("wr_req_latency", at, 0);
        check("wr_req_cycles", rc, 1);
        check("wr_bus_we", we, 1);
        check("wr_bus_addr", a, 32'h10);
        check("wr_bus_wdata", wd, 32'hDEADBEEF);
        check("wr_rsp_early", rsp_valid, 0);
        @(negedge clk);
        check("wr_rsp_latency", rsp_valid, 1);
        wait_drain("write");
        check("wr_rsp_hold_data", rsp_data, 0);

        // READ acked after three wait cycles
        expect_rsp(32'h12345678, 2'b00);
        send(32'h02, 32'h20, 32'h0);
        idle_in();
        serve(3, 32'h12345658, 20, rc, at, we, a, wd);
        check("rd_req_cycles", rc, 4);
        check("rd_bus_we", we, 0);
        check("rd_bus_addr", a, 32'h20);
        wait_drain("read");
        repeat (3) @(negedge clk);
        check("rd_rsp_hold_data", rsp_data, 32'h12345678);

        // Opcode upper bits ignored, NOP, invalid opcode
        expect_rsp(32'h0, 2'b00);
        send(32'hABCDEF01, 32'h30, 32'h55AA55AA);
        idle_in();
        serve(0, 32'h0, 10, rc, at, we, a, wd);
        check("hi_req_cycles", rc, 1);
        check("hi_bus_we", we, 1);
        check("hi_bus_wdata", wd, 32'h55AA55AA);
        wait_drain("hibits");

        expect_rsp(32'h0, 2'b00);
        send(32'h00, 32'h34, 32'h0);
        idle_in();
        serve(0, 32'h0, 6, rc, at, we, a, wd);
        check("nop_req_cycles", rc, 0);
        wait_drain("nop");

        expect_rsp(32'h0, 2'b01);
        send(32'h7F, 32'h38, 32'h0);
        idle_in();
        serve(0, 32'h0, 6, rc, at, we, a, wd);
        check("bad_req_cycles", rc, 0);
        wait_drain("badop");

        // Six back-to-back commands with ack held low: one executing, four queued, one dropped
        for (int i = 0; i < 6; i++) begin
            if (i < 5) expect_rsp(ovf_rd[i], 2'b00);
            send((i % 2 == 1) ? 32'h01 : 32'h02, 32'h100 + 32'(4 * i), 32'hC0DE0000 + 32'(i));
            if (i == 5) check("ovf_before_drop", overflow, 0);
        end
        idle_in();
        check("ovf_set", overflow, 1);
        check("ovf_busy", busy, 1);
        repeat (3) @(negedge clk);
        check("ovf_req_held", bus_req, 1);
        check("ovf_addr_held", bus_addr, 32'h100);
        for (int k = 0; k < 5; k++) begin
            serve(0, 32'h5A5A0000, 20, rc, at, we, a, wd);
            check($sformatf("ovf_req_cycles[%0d]", k), rc, 1);
            check($sformatf("ovf_addr[%0d]", k), a, 32'h100 + 32'(4 * k));
        end
        wait_drain("overflow");
        check("ovf_sticky", overflow, 1);
        check("ovf_busy_end", busy, 0);

        // Reset asserted mid-access
        send(32'h02, 32'h40, 32'h0);
        send(32'h01, 32'h44, 32'h1);
        idle_in();
        @(negedge clk);
        check("rst_mid_req_pre", bus_req, 1);
        #1;
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("rst_mid_req", bus_req, 0);
        check("rst_mid_rsp", rsp_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ovf", overflow, 0);
        check("rst_mid_addr", bus_addr, 0);
        @(negedge clk);
        reset   = 1'b1;
        bus_ack = 1'b1;
        repeat (6) @(negedge clk);
        bus_ack = 1'b0;
        check("rst_after_req", bus_req, 0);
        check("rst_after_busy", busy, 0);

        // Normal operation after reset
        expect_rsp(32'h0, 2'b00);
        send(32'h01, 32'h60, 32'h0BADF00D);
        idle_in();
        serve(0, 32'h0, 10, rc, at, we, a, wd);
        check("post_rst_req_cycles", rc, 1);
        check("post_rst_wdata", wd, 32'h0BADF00D);
        wait_drain("post_reset");

`ifdef MM_CMD_TIMEOUT_EN
        expect_rsp(32'h0, 2'b10);
        send(32'h02, 32'h50, 32'h0);
        idle_in();
        serve(1000, 32'hFFFF0000, 30, rc, at, we, a, wd);
        check("tmo_req_cycles", rc, TIMEOUT);
        wait_drain("timeout");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
